// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared size encodings, FSM state encoding and access-check
//            helpers for the multi-cycle data-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // funct3 access-size encodings
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  // Responder FSM states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Halves must be 2-byte aligned, words 4-byte aligned; bytes never fault.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      SZ_H, SZ_HU: return lane[0];
      SZ_W:        return (lane != 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

  // Unsigned sizes only make sense for loads; 011/110/111 are never legal.
  function automatic logic is_illegal_size(input logic [2:0] size, input logic we);
    case (size)
      SZ_B, SZ_H, SZ_W: return 1'b0;
      SZ_BU, SZ_HU:     return we;
      default:          return 1'b1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder_if
// Purpose  : Valid/ready request/response bundle between the core's MEM
//            stage (master) and the data-memory responder (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_responder_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_size;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DWIDTH-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane_align
// Purpose  : Combinational little-endian lane steering: extracts and extends
//            load data, and builds byte strobes plus replicated store data.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  size_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [3:0]  strb_o,
  output logic [31:0] wword_o
);

  logic [31:0] shifted;
  logic [15:0] half;

  // Load path: select the addressed byte/half and extend it
  always_comb begin
    shifted = word_i >> {lane_i, 3'b000};
    half    = lane_i[1] ? word_i[31:16] : word_i[15:0];
    rdata_o = 32'h0;
    case (size_i)
      SZ_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      SZ_BU:   rdata_o = {24'h0, shifted[7:0]};
      SZ_H:    rdata_o = {{16{half[15]}}, half};
      SZ_HU:   rdata_o = {16'h0, half};
      SZ_W:    rdata_o = word_i;
      default: rdata_o = 32'h0;
    endcase
  end

  // Store path: replicate data across lanes so the strobe alone picks bytes
  always_comb begin
    strb_o  = 4'b0000;
    wword_o = 32'h0;
    case (size_i)
      SZ_B: begin
        strb_o  = 4'b0001 << lane_i;
        wword_o = {4{wdata_i[7:0]}};
      end
      SZ_H: begin
        strb_o  = lane_i[1] ? 4'b1100 : 4'b0011;
        wword_o = {2{wdata_i[15:0]}};
      end
      SZ_W: begin
        strb_o  = 4'b1111;
        wword_o = wdata_i;
      end
      default: begin
        strb_o  = 4'b0000;
        wword_o = 32'h0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Multi-cycle data-memory target with valid/ready handshakes,
//            byte/half/word little-endian accesses and fixed response latency.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              we_q;
  logic [2:0]        size_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [DWIDTH-1:0] rdata_q;
  logic              err_q;
  logic [31:0]       ram_q [DEPTH_WORDS];

  logic              acc_we;
  logic [2:0]        acc_size;
  logic [AWIDTH-1:0] acc_addr;
  logic [DWIDTH-1:0] acc_wdata;
  logic              acc_oob;
  logic              acc_err;
  logic [IDX_W-1:0]  acc_idx;
  logic              enter_resp;
  logic [31:0]       ld_data;
  logic [3:0]        st_strb;
  logic [31:0]       st_word;

  // With LATENCY=1 the access happens on the accept edge itself, so the
  // live request is used in IDLE and the latched copy everywhere else.
  always_comb begin
    acc_we     = (state_q == S_IDLE) ? bus.req_we    : we_q;
    acc_size   = (state_q == S_IDLE) ? bus.req_size  : size_q;
    acc_addr   = (state_q == S_IDLE) ? bus.req_addr  : addr_q;
    acc_wdata  = (state_q == S_IDLE) ? bus.req_wdata : wdata_q;
    acc_oob    = (acc_addr[AWIDTH-1:2] >= (AWIDTH-2)'(DEPTH_WORDS));
    acc_idx    = acc_addr[IDX_W+1:2];
    acc_err    = acc_oob || is_misaligned(acc_size, acc_addr[1:0])
                 || is_illegal_size(acc_size, acc_we);
    enter_resp = (state_q != S_RESP) && (state_d == S_RESP);
  end

  dmem_lane_align u_align (
    .word_i  (ram_q[acc_idx]),
    .lane_i  (acc_addr[1:0]),
    .size_i  (acc_size),
    .wdata_i (acc_wdata),
    .rdata_o (ld_data),
    .strb_o  (st_strb),
    .wword_o (st_word)
  );

  // State and countdown registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state: IDLE accepts, WAIT counts down, RESP holds until taken
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            count_d = CNT_W'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        if (count_q == CNT_W'(1)) begin
          state_d = S_RESP;
          count_d = '0;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    bus.req_ready = (state_q == S_IDLE);
    bus.rsp_valid = (state_q == S_RESP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
  end

  // Capture the request on the accept edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if ((state_q == S_IDLE) && bus.req_valid) begin
      we_q    <= bus.req_we;
      size_q  <= bus.req_size;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  // Response payload is registered on the edge entering RESP and then frozen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      err_q   <= acc_err;
      rdata_q <= (acc_err || acc_we) ? '0 : ld_data;
    end
  end

  // RAM byte-lane write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (enter_resp && acc_we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (st_strb[b]) ram_q[acc_idx][8*b +: 8] <= st_word[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Multi-cycle data-memory responder: the target end of the core's load/store port, replacing the single-cycle DMEM model with a valid/ready request/response protocol. Accepts one request at a time and performs byte/half/word little-endian accesses using the funct3 size encoding. After a fixed, parameterised latency it returns a response carrying read data and an error flag. Sits between the pipelined core's MEM stage and on-chip data RAM.

Parameters:
DWIDTH, 32, data width in bits (fixed at 32 for lane logic)
AWIDTH, 32, byte-address width
DEPTH_WORDS, 1024, RAM depth in 32-bit words
LATENCY, 2, cycles from request accept edge to rsp_valid assertion, must be >= 1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  AWIDTH  byte address
req_wdata  in  DWIDTH  store data, low-order bytes used
rsp_valid  out  1  response present
rsp_ready  in  1  core accepts response
rsp_rdata  out  DWIDTH  load data, extended per size; 0 for stores and errors
rsp_err  out  1  misaligned, out-of-range or illegal size

Behaviour:
- One clock domain: clk. rst is asynchronous and active-high. On reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, countdown=0. RAM contents are not reset.
- FSM IDLE / WAIT / RESP:
  - IDLE: req_ready=1. On req_valid=1, the request is accepted at the edge. Latch we/size/addr/wdata. If LATENCY=1, go to RESP; otherwise go to WAIT with count=LATENCY-1.
  - WAIT: req_ready=0. Decrement count each cycle. When count reaches 1, go to RESP at the next edge.
  - RESP: rsp_valid=1, req_ready=0. rsp_rdata and rsp_err stay stable until rsp_ready=1. On that edge, go to IDLE; rsp_valid drops and req_ready rises in the following cycle.
- Timing: request accepted at edge t gives rsp_valid high in the cycle after edge t+LATENCY-1, i.e. LATENCY cycles after accept. Minimum request-to-request spacing is LATENCY+1 cycles with rsp_ready tied high.
- Requests while req_ready=0 are ignored. The initiator must hold its request until it is accepted.
- Addressing: word index = addr[AWIDTH-1:2]; lane = addr[1:0]; little-endian byte order.
- Loads:
  - B and BU extract byte lane; B sign-extends bit 7, BU zero-extends.
  - H and HU extract half lane addr[1]; H sign-extends bit 15, HU zero-extends.
  - W returns the full word.
- Stores:
  - B writes byte wdata[7:0] into the lane.
  - H writes wdata[15:0] into the half lane.
  - W writes the full word.
  - Other bytes of the word are untouched.
  - The write commits on the edge entering RESP, and only if there is no error.
- Error conditions, set on the same edge as the response data:
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - Word index >= DEPTH_WORDS.
  - size in {011, 110, 111}; also 100/101 with req_we=1.
  - On error: rsp_err=1, rsp_rdata=0, no RAM write.
- rsp_rdata=0 for all stores.
- Reset mid-transaction (WAIT or RESP): abort to IDLE. An uncommitted store is dropped. A store already committed (in RESP) stays.
- RAM is inferred as a synchronous array. The read result is registered into rsp_rdata on the edge entering RESP.

Decomposition:
- Package dmem_pkg:
  - Size localparams SZ_B=3'b000, SZ_H=3'b001, SZ_W=3'b010, SZ_BU=3'b100, SZ_HU=3'b101.
  - State encoding S_IDLE, S_WAIT, S_RESP.
  - Function is_misaligned(size, addr[1:0]).
- Sub-module dmem_lane_align (combinational):
  - Load path: word + lane + size -> extended rdata.
  - Store path: wdata + lane + size -> 4-bit byte strobe and lane-shifted write word.
- Top holds the FSM, countdown counter, request latches and RAM array.

Test Plan:
- LATENCY=2, store W 0xDEADBEEF @0x10, then load W @0x10 -> rsp_valid exactly 2 cycles after each accept; load rsp_rdata=0xDEADBEEF, rsp_err=0.
- Store B 0x80 @0x21, then load B @0x21 -> 0xFFFFFF80; load BU @0x21 -> 0x00000080; load W @0x20 shows only byte 1 changed.
- Store H 0x1234 @0x32, then load HU @0x32 -> 0x00001234; load H @0x30 unaffected.
- Load W @0x13, load H @0x11, size 011 @0x0, and a store to word index 1024 -> each returns rsp_err=1, rsp_rdata=0; RAM unchanged on readback.
- Hold rsp_ready=0 for 5 cycles in RESP while pulsing req_valid -> rsp_valid and rsp_rdata stable, req_ready=0, no second accept; first accept occurs the cycle after rsp_ready=1.
- Assert rst during WAIT of a store W 0xCAFEF00D @0x40 (location previously 0) -> outputs go to reset values immediately; a later load @0x40 returns 0x00000000.
